// File: rtl/dvp_frame_capture_if.sv
// DVP capture bus: camera pins, capture controls and frame-memory write port.
// slave = capture block; master = camera/controller side.
interface dvp_frame_capture_if #(
  parameter int ADDR_WIDTH = 19
);
  logic                  i_pclk;
  logic [7:0]            i_data;
  logic                  i_href;
  logic                  i_vsync;
  logic                  i_enable;
  logic                  i_single_shot;
  logic                  i_decimate;
  logic [11:0]           i_win_x0;
  logic [11:0]           i_win_y0;
  logic [15:0]           o_pixel_data;
  logic                  o_pixel_valid;
  logic                  o_we_memory;
  logic [ADDR_WIDTH-1:0] o_wr_address;
  logic                  o_frame_start;
  logic                  o_frame_done;
  logic                  o_busy;
  logic [7:0]            o_frame_count;
  logic                  o_err_line_len;
  logic                  o_err_frame;

  modport master (
    output i_pclk, i_data, i_href, i_vsync,
    output i_enable, i_single_shot, i_decimate,
    output i_win_x0, i_win_y0,
    input  o_pixel_data, o_pixel_valid,
    input  o_we_memory, o_wr_address,
    input  o_frame_start, o_frame_done,
    input  o_busy, o_frame_count,
    input  o_err_line_len, o_err_frame
  );

  modport slave (
    input  i_pclk, i_data, i_href, i_vsync,
    input  i_enable, i_single_shot, i_decimate,
    input  i_win_x0, i_win_y0,
    output o_pixel_data, o_pixel_valid,
    output o_we_memory, o_wr_address,
    output o_frame_start, o_frame_done,
    output o_busy, o_frame_count,
    output o_err_line_len, o_err_frame
  );
endinterface

// File: rtl/dvp_frame_capture.sv
// DVP camera capture: oversampled sync, pixel assembly, crop/decimate window,
// frame sequencing, counting and geometry error flags.
// Ports: i_clk, i_reset_n (async, active-low), bus (dvp_frame_capture_if.slave).
module dvp_frame_capture #(
  parameter int IMG_WIDTH       = 640,
  parameter int IMG_HEIGHT      = 480,
  parameter int OUT_WIDTH       = 640,
  parameter int OUT_HEIGHT      = 480,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int ADDR_WIDTH      = 19,
  parameter int VSYNC_FILTER    = 16
) (
  input logic                i_clk,
  input logic                i_reset_n,
  dvp_frame_capture_if.slave bus
);

  localparam int VSW = $clog2(VSYNC_FILTER + 1);
  localparam logic [VSW-1:0] VS_MAX = VSW'(VSYNC_FILTER);
  localparam logic [11:0] IMG_W = 12'(IMG_WIDTH);
  localparam logic [11:0] IMG_H = 12'(IMG_HEIGHT);
  localparam logic [13:0] OUT_W = 14'(OUT_WIDTH);
  localparam logic [13:0] OUT_H = 14'(OUT_HEIGHT);
  localparam logic [11:0] SAT = 12'hFFF;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(OUT_WIDTH * OUT_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE, WAIT_VS, WAIT_FRAME, CAPTURE
  } state_e;

  logic [2:0]            pclk_q;
  logic [2:0]            href_q;
  logic [1:0]            vs_q;
  logic [7:0]            d1_q;
  logic [7:0]            d2_q;
  logic [VSW-1:0]        vs_cnt_q;
  logic                  vs_on_q;
  state_e                state_q;
  logic                  hold_q;
  logic                  phase_q;
  logic [7:0]            hi_q;
  logic [15:0]           pix_q;
  logic                  valid_q;
  logic                  we_q;
  logic [11:0]           x_q;
  logic [11:0]           y_q;
  logic [11:0]           x0_q;
  logic [11:0]           y0_q;
  logic                  dec_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  full_q;
  logic                  start_q;
  logic                  done_q;
  logic                  err_line_q;
  logic                  err_frame_q;
  logic [7:0]            cnt_q;

  logic pclk_rise, href_rise, href_fall, byte_stb;
  logic vs_on, vs_rise, vs_fall;
  logic phase_eff, pix_done, capturing;
  logic in_x, in_y, we_d;
  logic [13:0] xw, yw, x_lo, y_lo, x_hi, y_hi;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pclk_q <= '0;
      href_q <= '0;
      vs_q   <= '0;
      d1_q   <= '0;
      d2_q   <= '0;
    end else begin
      pclk_q <= {pclk_q[1:0], bus.i_pclk};
      href_q <= {href_q[1:0], bus.i_href};
      vs_q   <= {vs_q[0], bus.i_vsync};
      d1_q   <= bus.i_data;
      d2_q   <= d1_q;
    end
  end

  assign pclk_rise = pclk_q[1] & ~pclk_q[2];
  assign href_rise = href_q[1] & ~href_q[2];
  assign href_fall = ~href_q[1] & href_q[2];
  assign byte_stb  = pclk_rise & href_q[1];

  assign vs_on   = (vs_cnt_q == VS_MAX);
  assign vs_rise = vs_on & ~vs_on_q;
  assign vs_fall = ~vs_on & vs_on_q;

  // A byte arriving with the href rise starts a fresh pixel.
  assign phase_eff = phase_q & ~href_rise;
  assign pix_done  = byte_stb &
                     ((BYTES_PER_PIXEL == 1) | phase_eff);
  assign capturing = (state_q == CAPTURE);

  assign xw   = {2'b00, x_q};
  assign yw   = {2'b00, y_q};
  assign x_lo = {2'b00, x0_q};
  assign y_lo = {2'b00, y0_q};
  assign x_hi = x_lo + (OUT_W << dec_q);
  assign y_hi = y_lo + (OUT_H << dec_q);

  // Even offset from the origin <=> same LSB as the origin.
  assign in_x = (xw >= x_lo) & (xw < x_hi) &
                (~dec_q | (x_q[0] == x0_q[0]));
  assign in_y = (yw >= y_lo) & (yw < y_hi) &
                (~dec_q | (y_q[0] == y0_q[0]));

  assign we_d = pix_done & capturing & in_x & in_y & ~full_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vs_cnt_q    <= '0;
      vs_on_q     <= 1'b0;
      state_q     <= IDLE;
      hold_q      <= 1'b0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      pix_q       <= '0;
      valid_q     <= 1'b0;
      we_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      dec_q       <= 1'b0;
      addr_q      <= '0;
      full_q      <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (!vs_q[1]) begin
        vs_cnt_q <= '0;
      end else if (vs_cnt_q != VS_MAX) begin
        vs_cnt_q <= vs_cnt_q + VSW'(1);
      end
      vs_on_q <= vs_on;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= pix_done;
      we_q    <= we_d;

      // Address sticks at the last slot; later pixels are dropped.
      if (we_q) begin
        if (addr_q == LAST_ADDR) begin
          full_q <= 1'b1;
        end else begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
        end
      end

      if (href_rise) begin
        phase_q <= 1'b0;
      end
      if (byte_stb) begin
        if (BYTES_PER_PIXEL == 1) begin
          pix_q <= {8'h00, d2_q};
        end else if (!phase_eff) begin
          hi_q    <= d2_q;
          phase_q <= 1'b1;
        end else begin
          pix_q   <= {hi_q, d2_q};
          phase_q <= 1'b0;
        end
      end

      if (pix_done && x_q != SAT) begin
        x_q <= x_q + 12'd1;
      end

      // Line end: a half-assembled pixel is thrown away.
      if (href_fall) begin
        x_q     <= '0;
        phase_q <= 1'b0;
        if (capturing) begin
          if (x_q != IMG_W) begin
            err_line_q <= 1'b1;
          end
          if (y_q != SAT) begin
            y_q <= y_q + 12'd1;
          end
        end
      end

      unique case (state_q)
        IDLE: begin
          // After a single shot, stay parked until enable is dropped.
          if (!bus.i_enable) begin
            hold_q <= 1'b0;
          end else if (!hold_q) begin
            state_q <= WAIT_VS;
          end
        end
        WAIT_VS: begin
          if (!bus.i_enable) begin
            state_q <= IDLE;
          end else if (vs_on) begin
            state_q <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (!bus.i_enable) begin
            state_q <= IDLE;
          end else if (vs_fall) begin
            state_q     <= CAPTURE;
            start_q     <= 1'b1;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
            addr_q      <= '0;
            full_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            x0_q        <= bus.i_win_x0;
            y0_q        <= bus.i_win_y0;
            dec_q       <= bus.i_decimate;
          end
        end
        CAPTURE: begin
          if (vs_rise) begin
            done_q <= 1'b1;
            cnt_q  <= cnt_q + 8'd1;
            if (y_q != IMG_H) begin
              err_frame_q <= 1'b1;
            end
            if (bus.i_single_shot || !bus.i_enable) begin
              state_q <= IDLE;
              hold_q  <= bus.i_single_shot;
            end else begin
              state_q <= WAIT_FRAME;
            end
          end
        end
      endcase
    end
  end

  assign bus.o_pixel_data   = pix_q;
  assign bus.o_pixel_valid  = valid_q;
  assign bus.o_we_memory    = we_q;
  assign bus.o_wr_address   = addr_q;
  assign bus.o_frame_start  = start_q;
  assign bus.o_frame_done   = done_q;
  assign bus.o_busy         = (state_q != IDLE);
  assign bus.o_frame_count  = cnt_q;
  assign bus.o_err_line_len = err_line_q;
  assign bus.o_err_frame    = err_frame_q;

endmodule
